uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed 8-bit receiver. It recovers frames from the serial line `info` using OVS-times oversampling and a 3-sample majority vote at mid-bit. It supports configurable data width, stop-bit count and runtime even/odd/none parity. It rejects start-bit glitches and reports parity, framing and break conditions. It sits between the line pin and the receiver FIFO: `flag` is the FIFO write enable and `fb` is the retransmit request to the transmitter.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync_vote.sv | 31 +++
 rtl/uart_rx_param.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM states and the
// default oversampling ratio.
package uart_pkg;

  localparam int OVS_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_sync_vote.sv
// Two-flop line synchronizer followed by a three-sample history and majority
// vote. The vote always covers the current synchronized sample and the two before it.
module uart_sync_vote (
  input  logic clk,
  input  logic areset_n,
  input  logic info,
  output logic si,
  output logic vote
);

  logic       sync1;
  logic       sync2;
  logic [1:0] hist;

  // Reset to the idle (high) level so leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 2'b11;
    end else begin
      sync1 <= info;
      sync2 <= sync1;
      hist  <= {hist[0], sync2};
    end
  end

  assign si   = sync2;
  assign vote = (si & hist[0]) | (si & hist[1]) | (hist[0] & hist[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start detection with glitch reject,
// DATA_W data bits LSB first, optional runtime parity, STOP_BITS stop bits, break detect.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OVS       = OVS_DEFAULT,
  parameter int STOP_BITS = 1
) (
  input  logic              rx_enbl,
  input  logic              areset_n,
  input  logic              info,
  input  logic              p_enbl,
  input  logic              p_odd,
  output logic [DATA_W-1:0] dout,
  output logic              flag,
  output logic              error,
  output logic              fb,
  output logic              perr,
  output logic              ferr,
  output logic              brk,
  output rx_state_t         state_dbg
);

  localparam int SW = $clog2(OVS);
  localparam int DW = $clog2(DATA_W + 1);

  localparam logic [SW-1:0] S_LAST    = SW'(OVS - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVS / 2 - 1);
  localparam logic [DW-1:0] D_LAST    = DW'(DATA_W - 1);
  localparam logic [DW-1:0] STOP_LAST = DW'(STOP_BITS - 1);

  rx_state_t         state;
  logic [SW-1:0]     s_cnt;
  logic [DW-1:0]     d_cnt;
  logic [DATA_W-1:0] temp;
  logic              par_en;
  logic              par_odd;
  logic              zeros;
  logic              si;
  logic              vote;

  logic first_stop;
  logic brk_now;
  logic err_now;

  uart_sync_vote u_sync_vote (
    .clk      (rx_enbl),
    .areset_n (areset_n),
    .info     (info),
    .si       (si),
    .vote     (vote)
  );

  // Frame verdict at the final stop sample. zeros already reflects the first
  // stop bit when a second one follows, so only the one-stop case needs vote here.
  assign first_stop = (d_cnt == '0);
  assign brk_now    = zeros & (~first_stop | ~vote);
  assign err_now    = perr | ferr | ~vote | brk_now;

  assign state_dbg = state;

  // flag and fb are single-cycle valid pulses with no ready: the FIFO and the
  // transmitter must accept them on the tick they are high.
  always_ff @(posedge rx_enbl or negedge areset_n) begin
    if (!areset_n) begin
      state   <= IDLE;
      s_cnt   <= '0;
      d_cnt   <= '0;
      temp    <= '0;
      par_en  <= 1'b0;
      par_odd <= 1'b0;
      zeros   <= 1'b0;
      dout    <= '0;
      flag    <= 1'b0;
      error   <= 1'b0;
      fb      <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      brk     <= 1'b0;
    end else begin
      flag <= 1'b0;
      fb   <= 1'b0;
      case (state)
        IDLE: begin
          s_cnt <= '0;
          d_cnt <= '0;
          if (!si) state <= START;
        end

        START: begin
          if (s_cnt == S_MID) begin
            s_cnt <= '0;
            if (vote) begin
              state <= IDLE;
            end else begin
              par_en  <= p_enbl;
              par_odd <= p_odd;
              error   <= 1'b0;
              perr    <= 1'b0;
              ferr    <= 1'b0;
              zeros   <= 1'b1;
              state   <= DATA;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end

        DATA: begin
          if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            temp  <= {vote, temp[DATA_W-1:1]};
            if (vote) zeros <= 1'b0;
            if (d_cnt == D_LAST) begin
              d_cnt <= '0;
              state <= par_en ? PARITY : STOP;
            end else begin
              d_cnt <= d_cnt + 1'b1;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            perr  <= vote != (^temp ^ par_odd);
            if (vote) zeros <= 1'b0;
            state <= STOP;
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end

        STOP: begin
          if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            if (!vote) ferr <= 1'b1;
            if (first_stop && vote) zeros <= 1'b0;
            if (d_cnt == STOP_LAST) begin
              d_cnt <= '0;
              if (err_now) begin
                error <= 1'b1;
                fb    <= 1'b1;
                if (brk_now) begin
                  brk   <= 1'b1;
                  state <= BRK_WAIT;
                end else begin
                  state <= IDLE;
                end
              end else begin
                dout  <= temp;
                flag  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              d_cnt <= d_cnt + 1'b1;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end

        BRK_WAIT: begin
          // s_cnt counts consecutive high samples; any low sample restarts it.
          if (!si) begin
            s_cnt <= '0;
          end else if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            brk   <= 1'b0;
            state <= IDLE;
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: a one-stop and a two-stop instance,
// directed cases plus randomized frames scored against a frame-level model.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int OVS    = 16;
  localparam int EW     = DATA_W + 4;

  // ---------------- clock / reset ----------------
  logic rx_enbl  = 1'b0;
  logic areset_n = 1'b0;
  always #5 rx_enbl = ~rx_enbl;

  logic info = 1'b1, p_enbl = 1'b0, p_odd = 1'b0;
  logic info2 = 1'b1, p_enbl2 = 1'b0, p_odd2 = 1'b0;

  logic [DATA_W-1:0] dout, dout2;
  logic flag, error, fb, perr, ferr, brk;
  logic flag2, error2, fb2, perr2, ferr2, brk2;
  rx_state_t state_dbg, state_dbg2;

  uart_rx_param #(.DATA_W(DATA_W), .OVS(OVS), .STOP_BITS(1)) u_dut (
    .rx_enbl(rx_enbl), .areset_n(areset_n), .info(info), .p_enbl(p_enbl), .p_odd(p_odd),
    .dout(dout), .flag(flag), .error(error), .fb(fb), .perr(perr), .ferr(ferr),
    .brk(brk), .state_dbg(state_dbg)
  );

  uart_rx_param #(.DATA_W(DATA_W), .OVS(OVS), .STOP_BITS(2)) u_dut2 (
    .rx_enbl(rx_enbl), .areset_n(areset_n), .info(info2), .p_enbl(p_enbl2), .p_odd(p_odd2),
    .dout(dout2), .flag(flag2), .error(error2), .fb(fb2), .perr(perr2), .ferr(ferr2),
    .brk(brk2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [DATA_W-1:0] last_good[2];
  logic last_err[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: outcome of one frame from its transmitted fields.
  // Packs {good, dout_after, perr, ferr, brk}.
  function automatic logic [EW-1:0] model(input int sel, input logic [DATA_W-1:0] d,
                                          input bit pen, input bit podd, input bit pbit,
                                          input int nstop, input logic [1:0] stops);
    bit pe, fe, bk, err;
    pe  = pen && (pbit != ((^d) ^ podd));
    fe  = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    bk  = (d == '0) && (!pen || pbit == 1'b0) && (stops[0] == 1'b0);
    err = pe || fe || bk;
    if (!err) last_good[sel] = d;
    last_err[sel] = err;
    return {!err, last_good[sel], pe, fe, bk};
  endfunction

  task automatic check_pulse(input int sel, input logic fl, input logic fbv, input logic er,
                             input logic [DATA_W-1:0] dv, input logic pe, input logic fe,
                             input logic bk);
    logic [EW-1:0] e;
    int qs;
    qs = (sel == 0) ? exp_q0.size() : exp_q1.size();
    if (qs == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_pulse dut%0d: flag=%0b fb=%0b, expected no pulse", sel, fl, fbv);
    end else begin
      e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("frame_result_dut%0d", sel),
            32'({fl, fbv, er, dv, pe, fe, bk}),
            32'({e[EW-1], !e[EW-1], !e[EW-1], e[EW-2:3], e[2], e[1], e[0]}));
    end
  endtask

  always @(negedge rx_enbl)
    if (areset_n && (flag || fb)) check_pulse(0, flag, fb, error, dout, perr, ferr, brk);

  always @(negedge rx_enbl)
    if (areset_n && (flag2 || fb2)) check_pulse(1, flag2, fb2, error2, dout2, perr2, ferr2, brk2);

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge rx_enbl);
    #1;
  endtask

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) info = b; else info2 = b;
  endtask

  task automatic set_par(input int sel, input logic pen, input logic podd);
    if (sel == 0) begin p_enbl = pen; p_odd = podd; end
    else begin p_enbl2 = pen; p_odd2 = podd; end
  endtask

  task automatic hold(input int sel, input logic b, input int n);
    set_line(sel, b);
    repeat (n) step();
  endtask

  task automatic drive_frame(input int sel, input logic [DATA_W-1:0] d, input bit pen,
                             input bit podd, input bit flip, input logic [1:0] stops,
                             input int gap);
    int nstop;
    logic pbit;
    logic [EW-1:0] e;
    nstop = (sel == 0) ? 1 : 2;
    pbit  = (^d) ^ podd ^ flip;
    e = model(sel, d, pen, podd, pbit, nstop, stops);
    if (sel == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    set_par(sel, pen, podd);
    hold(sel, 1'b0, OVS);
    for (int i = 0; i < DATA_W; i++) begin
      hold(sel, d[i], OVS);
      if (i == 1) set_par(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    if (pen) hold(sel, pbit, OVS);
    for (int s = 0; s < nstop; s++) hold(sel, stops[s], OVS);
    // A low final stop bit or a break needs a long idle before the next start edge.
    if (stops[nstop-1] == 1'b0 || e[0]) hold(sel, 1'b1, 2 * OVS);
    else hold(sel, 1'b1, gap);
  endtask

  task automatic random_frame(input int sel);
    logic [DATA_W-1:0] d;
    logic [1:0] stops;
    d = ($urandom_range(0, 7) == 0) ? '0 : DATA_W'($urandom);
    stops = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
    drive_frame(sel, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, stops, $urandom_range(1, 6));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    logic [EW-1:0] e;
    last_good[0] = '0; last_good[1] = '0;
    last_err[0]  = 1'b0; last_err[1] = 1'b0;

    repeat (3) step();
    check("reset_outputs_dut0", 32'({dout, flag, error, fb, perr, ferr, brk}), 32'(0));
    check("reset_outputs_dut1", 32'({dout2, flag2, error2, fb2, perr2, ferr2, brk2}), 32'(0));
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    areset_n = 1'b1;
    repeat (5) step();

    // 0xA5, even parity: latency from start detection to flag.
    fork
      drive_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 2'b11, 4);
    join_none
    cnt = 0;
    while (state_dbg != START && cnt < 50) begin @(negedge rx_enbl); cnt++; end
    check("start_detected", 32'(state_dbg == START), 32'(1));
    cnt = 0;
    do begin @(negedge rx_enbl); cnt++; end while (!flag && !fb && cnt < 400);
    check("latency_a5", 32'(cnt), 32'(OVS / 2 + OVS * (DATA_W + 1 + 1)));
    wait fork;
    check("a5_error_level", 32'(error), 32'(0));

    // 0x3C, odd parity, parity bit inverted.
    drive_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1, 2'b11, 4);
    check("parity_perr", 32'({perr, error}), 32'(2'b11));

    // Short low glitch on idle line.
    hold(0, 1'b0, 4);
    hold(0, 1'b1, 30);
    check("glitch_state", 32'(state_dbg), 32'(IDLE));
    check("glitch_outputs", 32'({dout, error}), 32'({last_good[0], last_err[0]}));

    // Two stop bits, both low, then a clean frame.
    drive_frame(1, 8'h55, 1'b0, 1'b0, 1'b0, 2'b00, 4);
    check("stop_ferr", 32'({ferr2, error2}), 32'(2'b11));
    drive_frame(1, 8'h0F, 1'b0, 1'b0, 1'b0, 2'b11, 4);
    check("clean_after_ferr", 32'({dout2, error2, ferr2}), 32'({8'h0F, 2'b00}));

    // Break: line low for two frame times.
    set_par(0, 1'b0, 1'b0);
    e = model(0, '0, 1'b0, 1'b0, 1'b0, 1, 2'b00);
    exp_q0.push_back(e);
    hold(0, 1'b0, 2 * OVS * 10);
    check("break_levels", 32'({brk, ferr, error}), 32'(3'b111));
    check("break_state", 32'(state_dbg), 32'(BRK_WAIT));
    hold(0, 1'b1, OVS);
    check("break_held", 32'(brk), 32'(1));
    repeat (3) step();
    check("break_cleared", 32'({brk, state_dbg}), 32'({1'b0, IDLE}));

    // Randomized frames.
    for (int n = 0; n < 40; n++) random_frame(0);
    for (int n = 0; n < 15; n++) random_frame(1);

    // Reset during the DATA phase.
    set_par(0, 1'b0, 1'b0);
    hold(0, 1'b0, OVS);
    hold(0, 1'b1, 3 * OVS);
    areset_n = 1'b0;
    #1;
    check("reset_mid_outputs", 32'({dout, flag, error, fb, perr, ferr, brk}), 32'(0));
    check("reset_mid_state", 32'(state_dbg), 32'(IDLE));
    last_good[0] = '0; last_good[1] = '0;
    last_err[0]  = 1'b0; last_err[1] = 1'b0;
    set_line(0, 1'b1);
    repeat (3) step();
    areset_n = 1'b1;
    repeat (5) step();
    drive_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, 2'b11, 4);
    check("after_reset_dout", 32'(dout), 32'(8'h81));

    repeat (20) step();
    check("queue0_drained", 32'(exp_q0.size()), 32'(0));
    check("queue1_drained", 32'(exp_q1.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
